// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types for the writeback arbiter.
//   REG_AW   : register-address width (x0..x31)
//   WB_XLEN  : data width carried by a buffered writeback request
//   wb_req_t : one register-file write (destination + data)
//   onehot32 : decoded destination, with x0 always cleared
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int REG_AW  = 5;
    localparam int WB_XLEN = 32;

    typedef struct packed {
        logic [REG_AW-1:0]  rd;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;

    // x0 is never a real write target, so its bit is forced low.
    function automatic logic [31:0] onehot32(input logic [REG_AW-1:0] rd);
        logic [31:0] v;
        v     = 32'd0;
        v[rd] = 1'b1;
        v[0]  = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Bundles the two producer handshakes (load unit, ALU), the register-file
// write port and the pending-destination mask.
//   master : the arbiter (consumes producer requests, drives the write port)
//   slave  : the environment (producers, register file, issue stage)
// ---------------------------------------------------------------------------
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN
);

    logic                ld_valid;
    logic                ld_ready;
    logic [REG_AW-1:0]   ld_rd;
    logic [XLEN-1:0]     ld_data;

    logic                alu_valid;
    logic                alu_ready;
    logic [REG_AW-1:0]   alu_rd;
    logic [XLEN-1:0]     alu_data;

    logic                reg_we;
    logic [REG_AW-1:0]   rd;
    logic [XLEN-1:0]     wd;
    logic [31:0]         pending_mask;

    modport master (
        input  ld_valid, ld_rd, ld_data,
        input  alu_valid, alu_rd, alu_data,
        output ld_ready, alu_ready,
        output reg_we, rd, wd, pending_mask
    );

    modport slave (
        output ld_valid, ld_rd, ld_data,
        output alu_valid, alu_rd, alu_data,
        input  ld_ready, alu_ready,
        input  reg_we, rd, wd, pending_mask
    );

endinterface

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO of wb_req_t used to hold ALU results while the
// write port is busy with loads.
//   clk, reset   : clock, asynchronous active-low reset (drops all entries)
//   i_push/data  : enqueue (ignored when full)
//   i_pop        : dequeue head (ignored when empty)
//   o_head       : current head entry (meaningful when !o_empty)
//   o_full/empty : occupancy flags, o_count : number of held entries
//   o_valid      : per-slot occupancy, o_slot_rd : per-slot destination
// ---------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  wb_req_t                       i_push_data,
    input  logic                          i_pop,
    output wb_req_t                       o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [DEPTH-1:0]              o_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  o_slot_rd
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head = r_mem[r_rd_ptr];

    // A slot is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [AW-1:0] w_off;
            assign w_off         = AW'(gi) - r_rd_ptr;
            assign o_valid[gi]   = ({1'b0, w_off} < r_count);
            assign o_slot_rd[gi] = r_mem[gi].rd;
        end
    endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Drives the register file's single write port from two producers: the
// variable-latency load unit and the ALU result stream. ALU results are
// buffered while loads hold the port; a starvation guard eventually forces
// the buffered head through, and pending_mask exposes buffered destinations.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : wb_arbiter_if.master (producer handshakes, write port, mask)
// Source priority each cycle: forced FIFO head > load > FIFO head > ALU
// bypass (FIFO empty only).
// ---------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int XLEN         = WB_XLEN   // must equal WB_XLEN (buffer type width)
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    // FIFO interface
    wb_req_t                       w_head;
    wb_req_t                       w_push_data;
    logic                          w_full;
    logic                          w_empty;
    logic [CNT_W-1:0]              w_count;
    logic [DEPTH-1:0]              w_valid;
    logic [DEPTH-1:0][REG_AW-1:0]  w_slot_rd;

    // Arbitration
    logic          w_force;
    logic          w_ld_write;
    logic          w_alu_room;
    logic          w_alu_keep;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;
    logic          w_win_we;
    wb_req_t       w_win;

    // State
    logic [SW-1:0]      r_starve;
    logic               r_reg_we;
    logic [REG_AW-1:0]  r_rd;
    logic [XLEN-1:0]    r_wd;

    logic [DEPTH-1:0][31:0] w_slot_mask;
    logic [31:0]            w_pmask;

    // Override applies only while there is a head to force.
    assign w_force    = !w_empty && (r_starve == SW'(STARVE_LIMIT));

    // A load to x0 completes its handshake but does not claim the port.
    assign w_ld_write = bus.ld_valid && !w_force && (bus.ld_rd != '0);

    // No same-cycle pop credit: a full FIFO refuses even while popping.
    assign w_alu_room = (w_count < CNT_W'(DEPTH));
    assign w_alu_keep = bus.alu_valid && w_alu_room && (bus.alu_rd != '0);

    assign w_pop      = !w_empty && (w_force || !w_ld_write);
    assign w_bypass   = w_empty && !w_ld_write && w_alu_keep;
    assign w_push     = w_alu_keep && !w_bypass && !w_full;

    assign w_push_data.rd   = bus.alu_rd;
    assign w_push_data.data = bus.alu_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_slot_rd   (w_slot_rd)
    );

    // Winner select: w_pop already folds in both the forced and the
    // uncontested head, and a forced cycle never accepts a load.
    always_comb begin
        w_win_we = 1'b0;
        w_win    = '0;
        if (w_pop) begin
            w_win_we = 1'b1;
            w_win    = w_head;
        end else if (w_ld_write) begin
            w_win_we   = 1'b1;
            w_win.rd   = bus.ld_rd;
            w_win.data = bus.ld_data;
        end else if (w_bypass) begin
            w_win_we   = 1'b1;
            w_win.rd   = bus.alu_rd;
            w_win.data = bus.alu_data;
        end
    end

    // Counts cycles the head loses to a load; any retirement or an empty
    // FIFO restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (w_empty || w_pop) begin
            r_starve <= '0;
        end else if (w_ld_write && (r_starve != SW'(STARVE_LIMIT))) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Output register: rd/wd hold their last value on idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_we <= 1'b0;
            r_rd     <= '0;
            r_wd     <= '0;
        end else begin
            r_reg_we <= w_win_we;
            if (w_win_we) begin
                r_rd <= w_win.rd;
                r_wd <= w_win.data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
            assign w_slot_mask[gi] = w_valid[gi] ? onehot32(w_slot_rd[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        w_pmask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pmask = w_pmask | w_slot_mask[i];
        end
    end

    assign bus.ld_ready     = !w_force;
    assign bus.alu_ready    = w_alu_room;
    assign bus.reg_we       = r_reg_we;
    assign bus.rd           = r_rd;
    assign bus.wd           = r_wd;
    assign bus.pending_mask = w_pmask;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed scoreboard bench for wb_arbiter. Stimulus pushes each expected
// register-file write (rd, data, cycle) into a queue; a negedge monitor pops
// and compares whenever reg_we is high. Ready/mask/reset values are checked
// directly against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;
    import wb_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8),
        .XLEN         (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Expected write appears on the next rising edge.
    task automatic exp_w(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.rd   = r;
        e.data = d;
        e.cyc  = cyc_n + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: every write-port assertion is matched against the queue.
    always @(negedge clk) begin
        if (reset && bus.reg_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got rd=%0d wd=%h cyc=%0d, want no write",
                         bus.rd, bus.wd, cyc_n);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rd !== mon_e.rd || bus.wd !== mon_e.data || cyc_n != mon_e.cyc) begin
                    n_bad++;
                    $display("FAIL wr_seq: got rd=%0d wd=%h cyc=%0d, want rd=%0d wd=%h cyc=%0d",
                             bus.rd, bus.wd, cyc_n, mon_e.rd, mon_e.data, mon_e.cyc);
                end else begin
                    $display("ok   write x%0d = %h at cyc %0d", bus.rd, bus.wd, cyc_n);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b0;
    endtask

    task automatic drv_ld(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.ld_valid = v;
        bus.ld_rd    = r;
        bus.ld_data  = d;
    endtask

    task automatic drv_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = r;
        bus.alu_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int ld_i;
        int alu_i;
        idle();
        bus.ld_rd    = '0;
        bus.ld_data  = '0;
        bus.alu_rd   = '0;
        bus.alu_data = '0;

        // ---------------- reset state ----------------
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_reg_we", {31'd0, bus.reg_we}, 32'd0);
        chk("rst_rd",     {27'd0, bus.rd}, 32'd0);
        chk("rst_wd",     bus.wd, 32'd0);
        chk("rst_pmask",  bus.pending_mask, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_ld_ready",  {31'd0, bus.ld_ready}, 32'd1);
        chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);

        // ---------------- ALU only: bypass ----------------
        drv_alu(1'b1, 5'd5, 32'h1234);
        #1;
        chk("t1_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        exp_w(5'd5, 32'h1234);
        cyc();
        idle();
        #1;
        chk("t1_pmask", bus.pending_mask, 32'd0);
        cyc();

        // ---------------- load + ALU same cycle ----------------
        drv_ld(1'b1, 5'd3, 32'hAAAA);
        drv_alu(1'b1, 5'd7, 32'hBBBB);
        #1;
        chk("t2_ld_ready",  {31'd0, bus.ld_ready}, 32'd1);
        chk("t2_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        exp_w(5'd3, 32'hAAAA);
        cyc();
        idle();
        #1;
        chk("t2_pmask_set", bus.pending_mask, 32'h0000_0080);
        exp_w(5'd7, 32'hBBBB);
        cyc();
        #1;
        chk("t2_pmask_clr", bus.pending_mask, 32'd0);
        cyc();

        // ---------------- push/pop at count=2 ----------------
        drv_ld(1'b1, 5'd20, 32'h100);
        drv_alu(1'b1, 5'd10, 32'h10);
        #1;
        exp_w(5'd20, 32'h100);
        cyc();
        drv_ld(1'b1, 5'd21, 32'h101);
        drv_alu(1'b1, 5'd11, 32'h11);
        #1;
        chk("t5_pmask_cnt1", bus.pending_mask, 32'h0000_0400);
        exp_w(5'd21, 32'h101);
        cyc();
        idle();
        drv_alu(1'b1, 5'd12, 32'h12);
        #1;
        chk("t5_pmask_cnt2", bus.pending_mask, 32'h0000_0C00);
        chk("t5_alu_ready",  {31'd0, bus.alu_ready}, 32'd1);
        exp_w(5'd10, 32'h10);
        cyc();
        idle();
        #1;
        chk("t5_pmask_pushpop", bus.pending_mask, 32'h0000_1800);
        exp_w(5'd11, 32'h11);
        cyc();
        #1;
        chk("t5_pmask_one", bus.pending_mask, 32'h0000_1000);
        exp_w(5'd12, 32'h12);
        cyc();
        #1;
        chk("t5_pmask_empty", bus.pending_mask, 32'd0);
        cyc();

        // ---------------- rd==0 load discard ----------------
        drv_ld(1'b1, 5'd22, 32'h222);
        drv_alu(1'b1, 5'd9, 32'h999);
        #1;
        exp_w(5'd22, 32'h222);
        cyc();
        drv_ld(1'b1, 5'd0, 32'hFFFF);
        bus.alu_valid = 1'b0;
        #1;
        chk("t4_ld_ready_x0", {31'd0, bus.ld_ready}, 32'd1);
        chk("t4_pmask_x9",    bus.pending_mask, 32'h0000_0200);
        exp_w(5'd9, 32'h999);
        cyc();
        idle();
        #1;
        chk("t4_pmask_clr", bus.pending_mask, 32'd0);
        cyc();

        // ---------------- FIFO fill + starvation ----------------
        ld_i  = 0;
        alu_i = 0;
        for (int c = 0; c < 11; c++) begin
            drv_ld(1'b1, 5'(1 + ld_i), 32'h500 + 32'(ld_i));
            drv_alu(alu_i < 5, 5'(24 + alu_i), 32'hA0 + 32'(alu_i));
            #1;
            chk("t3_ld_ready",  {31'd0, bus.ld_ready},  {31'd0, (c != 9)});
            chk("t3_alu_ready", {31'd0, bus.alu_ready}, {31'd0, (c < 4 || c == 10)});
            if (c == 9)
                chk("t3_pmask_full", bus.pending_mask, 32'h0F00_0000);
            if (c < 9)
                exp_w(5'(1 + c), 32'h500 + 32'(c));
            else if (c == 9)
                exp_w(5'd24, 32'hA0);
            else
                exp_w(5'd10, 32'h509);
            if (bus.ld_ready) ld_i++;
            if (bus.alu_valid && bus.alu_ready) alu_i++;
            cyc();
        end
        idle();
        for (int k = 1; k < 5; k++) begin
            #1;
            exp_w(5'(24 + k), 32'hA0 + 32'(k));
            cyc();
        end
        #1;
        chk("t3_pmask_drained", bus.pending_mask, 32'd0);
        chk("t3_alu_ready_end", {31'd0, bus.alu_ready}, 32'd1);
        cyc();

        // ---------------- async reset mid-burst ----------------
        for (int c = 0; c < 3; c++) begin
            drv_ld(1'b1, 5'(2 + c), 32'h700 + 32'(c));
            drv_alu(1'b1, 5'(13 + c), 32'h800 + 32'(c));
            #1;
            // The third load's write is cut off by reset before it is sampled.
            if (c < 2) exp_w(5'(2 + c), 32'h700 + 32'(c));
            cyc();
        end
        idle();
        chk("t6_we_before", {31'd0, bus.reg_we}, 32'd1);
        chk("t6_pmask_3",   bus.pending_mask, 32'h0000_E000);
        reset = 1'b0;
        #1;
        chk("t6_we_async",   {31'd0, bus.reg_we}, 32'd0);
        chk("t6_pmask_rst",  bus.pending_mask, 32'd0);
        chk("t6_rd_rst",     {27'd0, bus.rd}, 32'd0);
        chk("t6_wd_rst",     bus.wd, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t6_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("t6_ld_ready",  {31'd0, bus.ld_ready}, 32'd1);
        chk("t6_pmask_rel", bus.pending_mask, 32'd0);
        repeat (6) cyc();

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side driver of the register file's single write port (reg_we/rd/wd).
- Merges two producers onto that port: the load unit, which returns results at variable latency, and the ALU result stream.
- ALU results are buffered in a small FIFO while the port is taken by a load.
- A starvation guard stops the ALU FIFO from being blocked indefinitely, and a pending-destination mask lets the issue stage detect hazards on buffered writes.

Parameters:
- DEPTH, 4, number of ALU FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 8, consecutive lost cycles before the ALU head is forced through
- XLEN, 32, data width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ld_valid  in  1  load result valid
- ld_ready  out  1  load result accepted this cycle
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load result
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- reg_we  out  1  register-file write enable (registered)
- rd  out  5  register-file write address (registered)
- wd  out  XLEN  register-file write data (registered)
- pending_mask  out  32  bit i set when a buffered ALU write targets x_i

Behaviour:
- Reset (reset=0, asynchronous):
  - reg_we=0, rd=0, wd=0.
  - FIFO empty, starvation counter=0, pending_mask=0.
  - ld_ready=1 and alu_ready=1 from the first cycle after reset release.
- Handshake: a transfer occurs on a rising edge with valid&ready; valid/rd/data hold stable until accepted.
- Write-port sources, in priority order each cycle:
  - (a) forced ALU FIFO head (starve override)
  - (b) load input
  - (c) ALU FIFO head
  - (d) ALU input bypass, only when FIFO is empty and neither (b) nor (c) applies
- Output register: the winner's rd/data load into rd/wd with reg_we=1 on the next edge. When no source wins: reg_we=0, and rd/wd hold their previous values.
- Latency: a load, or an ALU result via bypass, reaches reg_we exactly 1 cycle after acceptance. A buffered ALU entry reaches reg_we 1 cycle after it becomes the winning head.
- ld_ready: 0 only in a starve-override cycle, otherwise 1.
- alu_ready: (count < DEPTH). No same-cycle pop credit, so a full FIFO refuses even while popping.
- ALU enqueue: an accepted ALU result that does not take the bypass is pushed to the FIFO tail. Push and pop in the same cycle are allowed; count stays unchanged.
- rd==0 results:
  - Accepted normally (handshake completes).
  - Discarded: never enqueued, never drive reg_we=1.
  - A discarded load does not consume the port, so the FIFO head may win that cycle.
- Ordering:
  - ALU writes retire in program order (FIFO order; the bypass is used only when the FIFO is empty).
  - No ordering between loads and ALU results is enforced. The issue stage must prevent WAW using pending_mask plus its own load scoreboard.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and its head loses to a load.
  - Clears when the head retires or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT, the next cycle is a starve-override cycle: head forced, ld_ready=0. The counter clears when that head retires.
- pending_mask:
  - Combinational OR over valid FIFO entries of onehot(rd); bit 0 is always 0.
  - Updates on the same edge as push/pop.
  - Excludes the bypass path and the output register.
- Reset mid-operation: FIFO contents and any in-flight output are dropped, and reg_we deasserts immediately (asynchronous).

Decomposition:
- Package wb_pkg:
  - REG_AW=5
  - wb_req_t struct {logic [4:0] rd; logic [XLEN-1:0] data;}
  - function onehot32(rd)
- One sub-module, wb_fifo: synchronous FIFO of wb_req_t (DEPTH entries), with push/pop/full/empty/count and an entry-valid vector exposed for pending_mask.

Test Plan:
- Reset then ALU only: alu (rd=5, 0x1234) in cycle 0 → next cycle reg_we=1, rd=5, wd=0x1234; FIFO stays empty, pending_mask=0.
- Load and ALU in the same cycle: ld (rd=3, 0xAAAA), alu (rd=7, 0xBBBB) → write x3=0xAAAA, then x7=0xBBBB one cycle later; pending_mask[7]=1 for exactly one cycle.
- FIFO fill: ld_valid held 1 with distinct rds, 5 ALU pushes → alu_ready=0 once 4 entries are held; then STARVE_LIMIT=8 losses force ld_ready=0 for one cycle and the head writes out.
- rd==0 discard: ld (rd=0, 0xFFFF) together with FIFO head (rd=9) → ld handshake completes, x9 is written, no write to x0.
- Push/pop same cycle at count=2 with no load → count remains 2; order preserved (verify wd sequence 0x10, 0x11, 0x12).
- Async reset asserted mid-burst with FIFO at 3 entries → reg_we=0 immediately; after release pending_mask=0, alu_ready=1, and no stale writes appear.
